// File: rtl/zc_pkg.sv
// Shared widths and FSM encoding for the Zadoff-Chu phase generator.
package zc_pkg;

  localparam int MZC_W     = 10;
  localparam int REC_W     = 30;
  localparam int PH_W      = 16;
  localparam int REC_SHIFT = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } zc_state_e;

endpackage

// File: rtl/zc_mod_add.sv
// Modular add (a + b) mod n for operands already reduced below n.
module zc_mod_add
  import zc_pkg::*;
#(
  parameter int W = MZC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] y
);

  logic [W:0] sum;
  logic [W:0] diff;

  // a + b < 2n, so one conditional subtract fully reduces the sum.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = sum - {1'b0, n};
  assign y    = (sum >= {1'b0, n}) ? diff[W-1:0] : sum[W-1:0];

endmodule

// File: rtl/zc_phase_gen.sv
// Zadoff-Chu phase generator: emits -q*n*(n+1)/(2*Nzc) turns for m = 0..Mzc-1
// using a divider-free quadratic recurrence and a reciprocal multiply.
module zc_phase_gen
  import zc_pkg::*;
#(
  parameter int PH_W      = zc_pkg::PH_W,
  parameter int REC_SHIFT = zc_pkg::REC_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MZC_W-1:0] Mzc,
  input  logic [MZC_W-1:0] Nzc,
  input  logic [REC_W-1:0] Nzc_rec,
  input  logic [MZC_W-1:0] q,
  input  logic             out_ready,
  output logic             phase_valid,
  output logic [PH_W-1:0]  phase,
  output logic [MZC_W-1:0] m_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PROD_W = REC_W + MZC_W;

  zc_state_e state;

  logic [MZC_W-1:0] mzc_cfg;
  logic [MZC_W-1:0] nzc_cfg;
  logic [MZC_W-1:0] q_cfg;
  logic [REC_W-1:0] rec_cfg;

  logic             vld_p1;
  logic [MZC_W-1:0] n_p1;
  logic [MZC_W-1:0] r_p1;
  logic [MZC_W-1:0] d_p1;
  logic [MZC_W-1:0] m_p1;
  logic [MZC_W-1:0] r_nxt_p1;
  logic [MZC_W-1:0] d_nxt_p1;

  logic             vld_p2;
  logic [PH_W-1:0]  frac_p2;
  logic [MZC_W-1:0] m_p2;

  logic q_ok;
  logic accept;
  logic take_p2;
  logic adv_p1;
  logic last_p1;
  logic wrap_p1;
  logic last_p2;

  // Fraction of a turn for r/Nzc, kept before the final negation.
  function automatic logic [PH_W-1:0] frac_of(input logic [MZC_W-1:0] r,
                                              input logic [REC_W-1:0] rec);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(r) * PROD_W'(rec);
    return PH_W'(prod >> REC_SHIFT);
  endfunction

  // Negative rotation, modulo one full turn; zero stays zero.
  function automatic logic [PH_W-1:0] neg_turn(input logic [PH_W-1:0] p);
    return PH_W'(-p);
  endfunction

  assign q_ok    = (q != '0) && (q < Nzc);
  assign accept  = (state == ST_IDLE) && start && q_ok;
  assign take_p2 = !vld_p2 || out_ready;
  assign adv_p1  = vld_p1 && take_p2;
  assign last_p1 = (m_p1 == mzc_cfg - MZC_W'(1));
  assign wrap_p1 = (n_p1 == nzc_cfg - MZC_W'(1));
  assign last_p2 = (m_p2 == mzc_cfg - MZC_W'(1));

  zc_mod_add #(.W(MZC_W)) u_add_r (
    .a (r_p1),
    .b (d_p1),
    .n (nzc_cfg),
    .y (r_nxt_p1)
  );

  zc_mod_add #(.W(MZC_W)) u_add_d (
    .a (d_p1),
    .b (q_cfg),
    .n (nzc_cfg),
    .y (d_nxt_p1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else begin
      err <= (state == ST_IDLE) && start && !q_ok;
      case (state)
        ST_IDLE:  if (accept)            state <= ST_RUN;
        ST_RUN:   if (adv_p1 && last_p1) state <= ST_FLUSH;
        ST_FLUSH: if (done)              state <= ST_IDLE;
        default:                         state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mzc_cfg <= Mzc;
      nzc_cfg <= Nzc;
      q_cfg   <= q;
      rec_cfg <= Nzc_rec;
    end
  end

  // ---- stage 1: quadratic recurrence r = q*n*(n+1)/2 mod Nzc ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      n_p1   <= '0;
      r_p1   <= '0;
      d_p1   <= '0;
      m_p1   <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      n_p1   <= '0;
      r_p1   <= '0;
      d_p1   <= q;
      m_p1   <= '0;
    end else if (adv_p1) begin
      m_p1 <= m_p1 + MZC_W'(1);
      if (last_p1) vld_p1 <= 1'b0;
      if (wrap_p1) begin
        n_p1 <= '0;
        r_p1 <= '0;
        d_p1 <= q_cfg;
      end else begin
        n_p1 <= n_p1 + MZC_W'(1);
        r_p1 <= r_nxt_p1;
        d_p1 <= d_nxt_p1;
      end
    end
  end

  // ---- stage 2: reciprocal multiply, registered ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      frac_p2 <= '0;
      m_p2    <= '0;
    end else if (take_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        frac_p2 <= frac_of(r_p1, rec_cfg);
        m_p2    <= m_p1;
      end
    end
  end

  assign phase_valid = vld_p2;
  assign phase       = neg_turn(frac_p2);
  assign m_idx       = m_p2;
  assign busy        = (state != ST_IDLE);
  assign done        = vld_p2 && out_ready && last_p2;

endmodule

// File: tb/tb_zc_phase_gen.sv
// Directed bench for zc_phase_gen with hand-computed phase values (Nzc = 31).
module tb_zc_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  Mzc;
  logic [9:0]  Nzc;
  logic [29:0] Nzc_rec;
  logic [9:0]  q;
  logic        out_ready;
  logic        phase_valid;
  logic [15:0] phase;
  logic [9:0]  m_idx;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int          got;
  int          done_cnt;
  int          done_m;
  int          err_cnt;
  bit          order_ok;
  logic [15:0] ph [0:63];

  always #5 clk = ~clk;

  zc_phase_gen #(.PH_W(16), .REC_SHIFT(18)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Mzc         (Mzc),
    .Nzc         (Nzc),
    .Nzc_rec     (Nzc_rec),
    .q           (q),
    .out_ready   (out_ready),
    .phase_valid (phase_valid),
    .phase       (phase),
    .m_idx       (m_idx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Records every accepted sample until the generator goes idle or the budget runs out.
  task automatic collect(input int first_m, input int budget, input bit inject);
    int exp_m;
    exp_m    = first_m;
    got      = 0;
    done_cnt = 0;
    done_m   = -1;
    err_cnt  = 0;
    order_ok = 1'b1;
    for (int i = 0; i < 64; i++) ph[i] = 'x;
    for (int c = 0; c < budget; c++) begin
      if (inject) start = (c == 3);
      if (err) err_cnt++;
      if (phase_valid && out_ready) begin
        if (int'(m_idx) != exp_m) order_ok = 1'b0;
        if (m_idx < 64) ph[m_idx] = phase;
        if (done) begin
          done_cnt++;
          done_m = int'(m_idx);
        end
        got++;
        exp_m++;
      end
      tick();
      if (got > 0 && !busy && !phase_valid) break;
    end
    start = 1'b0;
  endtask

  task automatic launch(input int mzc, input int qv);
    Mzc   = 10'(mzc);
    q     = 10'(qv);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    start     = 1'b0;
    Mzc       = 10'd36;
    Nzc       = 10'd31;
    Nzc_rec   = 30'd554189329;
    q         = 10'd1;
    out_ready = 1'b1;
    tick();
    tick();

    chk("rst_valid", 32'(phase_valid), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_midx", 32'(m_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    // q = 1, full sequence with wrap at n = 31
    launch(36, 1);
    chk("a_busy_c1", 32'(busy), 1);
    chk("a_valid_c1", 32'(phase_valid), 0);
    tick();
    chk("a_valid_c2", 32'(phase_valid), 1);
    chk("a_midx0", 32'(m_idx), 0);
    collect(0, 80, 1'b0);
    chk("a_count", got, 36);
    chk("a_order", 32'(order_ok), 1);
    chk("a_ph0", 32'(ph[0]), 0);
    chk("a_ph1", 32'(ph[1]), 63422);
    chk("a_ph2", 32'(ph[2]), 59194);
    chk("a_ph3", 32'(ph[3]), 52852);
    chk("a_ph31", 32'(ph[31]), 0);
    chk("a_ph32", 32'(ph[32]), 63422);
    chk("a_ph35", 32'(ph[35]), 44396);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_done_m", done_m, 35);
    chk("a_busy_end", 32'(busy), 0);

    // q = 30 mirrors q = 1
    launch(36, 30);
    tick();
    collect(0, 80, 1'b0);
    chk("b_count", got, 36);
    chk("b_ph1", 32'(ph[1]), 2115);
    chk("b_ph2", 32'(ph[2]), 6343);
    chk("b_done_m", done_m, 35);

    // backpressure at m = 5
    launch(36, 1);
    k = 0;
    while (!(phase_valid && m_idx == 10'd5) && k < 20) begin
      tick();
      k++;
    end
    chk("c_reach5", 32'(m_idx), 5);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("c_hold_valid", 32'(phase_valid), 1);
      chk("c_hold_midx", 32'(m_idx), 5);
      chk("c_hold_phase", 32'(phase), 33826);
    end
    out_ready = 1'b1;
    collect(5, 80, 1'b0);
    chk("c_count", got, 31);
    chk("c_order", 32'(order_ok), 1);
    chk("c_ph5", 32'(ph[5]), 33826);
    chk("c_ph6", 32'(ph[6]), 21141);
    chk("c_done_m", done_m, 35);

    // rejected starts
    launch(36, 31);
    chk("d_err31", 32'(err), 1);
    chk("d_busy31", 32'(busy), 0);
    chk("d_valid31", 32'(phase_valid), 0);
    tick();
    chk("d_err31_off", 32'(err), 0);
    chk("d_valid31_b", 32'(phase_valid), 0);
    chk("d_busy31_b", 32'(busy), 0);
    launch(36, 0);
    chk("d_err0", 32'(err), 1);
    chk("d_busy0", 32'(busy), 0);
    tick();
    chk("d_err0_off", 32'(err), 0);
    chk("d_valid0", 32'(phase_valid), 0);

    // reset at m = 10, then restart
    launch(36, 1);
    k = 0;
    while (!(phase_valid && m_idx == 10'd10) && k < 30) begin
      tick();
      k++;
    end
    chk("e_reach10", 32'(m_idx), 10);
    rst_n = 1'b0;
    tick();
    chk("e_valid", 32'(phase_valid), 0);
    chk("e_phase", 32'(phase), 0);
    chk("e_midx", 32'(m_idx), 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_done", 32'(done), 0);
    chk("e_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();
    launch(36, 1);
    tick();
    chk("e_restart_valid", 32'(phase_valid), 1);
    chk("e_restart_midx", 32'(m_idx), 0);
    collect(0, 80, 1'b0);
    chk("e_count", got, 36);
    chk("e_done_cnt", done_cnt, 1);

    // start pulsed while running with a different root
    launch(36, 1);
    q = 10'd7;
    tick();
    collect(0, 80, 1'b1);
    chk("f_count", got, 36);
    chk("f_ph1", 32'(ph[1]), 63422);
    chk("f_err", err_cnt, 0);
    chk("f_done_cnt", done_cnt, 1);

    // short sequence, no wrap
    launch(3, 1);
    tick();
    collect(0, 20, 1'b0);
    chk("g_count", got, 3);
    chk("g_ph2", 32'(ph[2]), 59194);
    chk("g_done_m", done_m, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
